// File: rtl/tester_secuencial_if.sv
`default_nettype none
// ============================================================================
// Module   : tester_secuencial_if
// Purpose  : Operand/product handshake between the tester and the multiplier.
// Revision : 1.0
// ============================================================================
interface tester_secuencial_if #(
    parameter int K = 4
);
    logic [K-1:0]   a_valor;
    logic [K-1:0]   b_valor;
    logic           iniciar;
    logic           listo;
    logic [2*K-1:0] resultado;

    modport master (output a_valor, output b_valor, output iniciar,
                    input  listo,   input  resultado);
    modport slave  (input  a_valor, input  b_valor, input  iniciar,
                    output listo,   output resultado);
endinterface
`default_nettype wire

// File: rtl/tester_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : tester_secuencial
// Purpose  : Sweep/LFSR operand sequencer that scores a shift-add multiplier.
// Revision : 1.0
// ============================================================================
module tester_secuencial #(
    parameter int          K         = 4,
    parameter int          N_PRUEBAS = 16,
    parameter int          MODO      = 0,
    parameter logic [63:0] SEMILLA   = 64'h5A,
    parameter logic [63:0] TAPS      = 64'hB8,
    parameter int          TIMEOUT   = 64,
    parameter int          ERR_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             habilitar_i,
    output logic                  fin_o,
    output logic [ERR_W-1:0]      errores_o,
    output logic                  timeout_err_o,
    tester_secuencial_if.master   mul_if
);
    typedef logic [2*K-1:0] vec_t;

    localparam int IDX_W  = (N_PRUEBAS > 1) ? $clog2(N_PRUEBAS) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT);

    localparam vec_t              c_SEED      = vec_t'(SEMILLA);
    localparam vec_t              c_TAPS      = vec_t'(TAPS);
    localparam vec_t              c_V0        = (MODO == 1) ? c_SEED : '0;
    localparam logic [IDX_W-1:0]  c_IDX_LAST  = IDX_W'(N_PRUEBAS - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [ERR_W-1:0]  c_ERR_MAX   = '1;

    localparam logic [1:0] c_REPOSO = 2'd0;
    localparam logic [1:0] c_INICIO = 2'd1;
    localparam logic [1:0] c_ESPERA = 2'd2;
    localparam logic [1:0] c_FIN    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [K-1:0]      a_q, a_d, b_q, b_d;
    vec_t              vec_q, vec_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic              tmo_q, tmo_d;

    logic   w_iniciar, w_fin, w_match, w_tc, w_score, w_last;
    vec_t   w_prod, w_vec_nx;

    // vec_q holds the generator state of the vector currently on A/B.
    function automatic vec_t f_step(input vec_t s);
        if (MODO == 1) return {s[2*K-2:0], ^(s & c_TAPS)};
        else           return s + 1'b1;
    endfunction

    assign w_prod   = {{K{1'b0}}, a_q} * {{K{1'b0}}, b_q};
    assign w_match  = (mul_if.resultado == w_prod);
    assign w_tc     = (cnt_q == c_WAIT_LAST);
    assign w_score  = (state_q == c_ESPERA) && (mul_if.listo || w_tc);
    assign w_last   = (idx_q == c_IDX_LAST);
    assign w_vec_nx = f_step(vec_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= c_REPOSO;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_REPOSO: if (habilitar_i) state_d = c_INICIO;
            c_INICIO: state_d = c_ESPERA;
            c_ESPERA: if (w_score) state_d = w_last ? c_FIN : c_INICIO;
            c_FIN:    if (!habilitar_i) state_d = c_REPOSO;
            default:  state_d = c_REPOSO;
        endcase
    end

    always_comb begin
        w_iniciar = (state_q == c_INICIO);
        w_fin     = (state_q == c_FIN);
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        vec_d = vec_q;
        idx_d = idx_q;
        cnt_d = cnt_q;
        err_d = err_q;
        tmo_d = tmo_q;
        case (state_q)
            c_REPOSO: if (habilitar_i) begin
                vec_d = c_V0;
                a_d   = c_V0[K-1:0];
                b_d   = c_V0[2*K-1:K];
                idx_d = '0;
                err_d = '0;
                tmo_d = 1'b0;
            end
            c_INICIO: cnt_d = '0;
            c_ESPERA: if (w_score) begin
                // listo takes priority over the terminal count
                if (!mul_if.listo) tmo_d = 1'b1;
                if ((!mul_if.listo || !w_match) && (err_q != c_ERR_MAX))
                    err_d = err_q + 1'b1;
                if (!w_last) begin
                    idx_d = idx_q + 1'b1;
                    vec_d = w_vec_nx;
                    a_d   = w_vec_nx[K-1:0];
                    b_d   = w_vec_nx[2*K-1:K];
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            vec_q <= c_SEED;
            idx_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            vec_q <= vec_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            tmo_q <= tmo_d;
        end
    end

    assign mul_if.a_valor = a_q;
    assign mul_if.b_valor = b_q;
    assign mul_if.iniciar = w_iniciar;
    assign fin_o          = w_fin;
    assign errores_o      = err_q;
    assign timeout_err_o  = tmo_q;
endmodule
`default_nettype wire

// File: tb/tb_tester_secuencial.sv
`default_nettype none
// ============================================================================
// Module   : tb_tester_secuencial
// Purpose  : Directed bench: four tester configurations against small multiplier models.
// Revision : 1.0
// ============================================================================
module tb_tester_secuencial;
    typedef struct { logic [3:0] a; logic [3:0] b; } vec_rec_t;
    typedef struct { logic inject; logic [3:0] inj_a; logic [15:0] exp_err; int exp_cycles; } run_rec_t;

    logic clk;
    logic rst0_n, rst1_n, rst2_n, rst3_n;
    logic hab0, hab1, hab2, hab3;
    logic fin0, fin1, fin2, fin3;
    logic tmo0, tmo1, tmo2, tmo3;
    logic [15:0] err0, err1, err2;
    logic [1:0]  err3;
    logic        inject0;
    logic [3:0]  inj_a0;
    logic [2:0]  sh0;
    logic [7:0]  log0[$], log1[$], log2[$];
    int n_chk, n_fail;

    tester_secuencial_if #(.K(4)) if0();
    tester_secuencial_if #(.K(4)) if1();
    tester_secuencial_if #(.K(4)) if2();
    tester_secuencial_if #(.K(4)) if3();

    tester_secuencial #(.K(4), .N_PRUEBAS(4), .MODO(0), .TIMEOUT(64), .ERR_W(16)) u0 (
        .clk(clk), .rst_n(rst0_n), .habilitar_i(hab0), .fin_o(fin0),
        .errores_o(err0), .timeout_err_o(tmo0), .mul_if(if0));
    tester_secuencial #(.K(4), .N_PRUEBAS(3), .MODO(0), .TIMEOUT(8), .ERR_W(16)) u1 (
        .clk(clk), .rst_n(rst1_n), .habilitar_i(hab1), .fin_o(fin1),
        .errores_o(err1), .timeout_err_o(tmo1), .mul_if(if1));
    tester_secuencial #(.K(4), .N_PRUEBAS(6), .MODO(1), .SEMILLA(64'h5A), .TAPS(64'hB8),
                        .TIMEOUT(64), .ERR_W(16)) u2 (
        .clk(clk), .rst_n(rst2_n), .habilitar_i(hab2), .fin_o(fin2),
        .errores_o(err2), .timeout_err_o(tmo2), .mul_if(if2));
    tester_secuencial #(.K(4), .N_PRUEBAS(5), .MODO(0), .TIMEOUT(64), .ERR_W(2)) u3 (
        .clk(clk), .rst_n(rst3_n), .habilitar_i(hab3), .fin_o(fin3),
        .errores_o(err3), .timeout_err_o(tmo3), .mul_if(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // u0: listo on the third ESPERA cycle, optional +1 corruption on one A value
    always @(posedge clk or negedge rst0_n) begin
        if (!rst0_n) sh0 <= '0;
        else         sh0 <= {sh0[1:0], if0.iniciar};
    end
    assign if0.listo     = sh0[2];
    assign if0.resultado = {4'b0, if0.a_valor} * {4'b0, if0.b_valor}
                         + ((inject0 && (if0.a_valor == inj_a0)) ? 8'd1 : 8'd0);
    assign if1.listo     = 1'b0;
    assign if1.resultado = 8'd0;
    assign if2.listo     = 1'b1;
    assign if2.resultado = {4'b0, if2.a_valor} * {4'b0, if2.b_valor};
    assign if3.listo     = 1'b1;
    assign if3.resultado = {4'b0, if3.a_valor} * {4'b0, if3.b_valor} + 8'd1;

    always @(posedge clk) begin
        if (if0.iniciar) log0.push_back({if0.a_valor, if0.b_valor});
        if (if1.iniciar) log1.push_back({if1.a_valor, if1.b_valor});
        if (if2.iniciar) log2.push_back({if2.a_valor, if2.b_valor});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_rec_t sweep[4];
        vec_rec_t lfsr[6];
        run_rec_t runs[2];
        int n;

        sweep[0] = '{4'h0, 4'h0}; sweep[1] = '{4'h1, 4'h0};
        sweep[2] = '{4'h2, 4'h0}; sweep[3] = '{4'h3, 4'h0};
        // 5A -> B4 -> 69 -> D2 -> A4 -> 48 with taps 7,5,4,3
        lfsr[0] = '{4'hA, 4'h5}; lfsr[1] = '{4'h4, 4'hB}; lfsr[2] = '{4'h9, 4'h6};
        lfsr[3] = '{4'h2, 4'hD}; lfsr[4] = '{4'h4, 4'hA}; lfsr[5] = '{4'h8, 4'h4};
        runs[0] = '{1'b0, 4'h2, 16'd0, 16};
        runs[1] = '{1'b1, 4'h2, 16'd1, 16};

        n_chk = 0; n_fail = 0;
        rst0_n = 0; rst1_n = 0; rst2_n = 0; rst3_n = 0;
        hab0 = 0; hab1 = 0; hab2 = 0; hab3 = 0;
        inject0 = 0; inj_a0 = 4'h2;
        repeat (2) @(negedge clk);
        chk("rst_a", {28'd0, if0.a_valor}, 0);
        chk("rst_b", {28'd0, if0.b_valor}, 0);
        chk("rst_iniciar", {31'd0, if0.iniciar}, 0);
        chk("rst_fin", {31'd0, fin0}, 0);
        chk("rst_err", {16'd0, err0}, 0);
        chk("rst_tmo", {31'd0, tmo0}, 0);
        rst0_n = 1; rst1_n = 1; rst2_n = 1; rst3_n = 1;
        @(negedge clk);

        // Sweep runs on u0: clean then one corrupted product
        for (int r = 0; r < 2; r++) begin
            inject0 = runs[r].inject; inj_a0 = runs[r].inj_a;
            log0.delete();
            hab0 = 1;
            @(posedge clk); #1;
            chk("start_iniciar", {31'd0, if0.iniciar}, 1);
            chk("start_a", {28'd0, if0.a_valor}, 0);
            n = 0;
            while (!fin0 && n < 200) begin
                @(posedge clk); #1; n++;
                if (n == 1) chk("iniciar_one_cycle", {31'd0, if0.iniciar}, 0);
            end
            chk("run_cycles", n, runs[r].exp_cycles);
            chk("run_err", {16'd0, err0}, {16'd0, runs[r].exp_err});
            chk("run_tmo", {31'd0, tmo0}, 0);
            chk("hold_a", {28'd0, if0.a_valor}, 3);
            chk("log_size", log0.size(), 4);
            for (int i = 0; i < 4; i++)
                if (log0.size() > i)
                    chk($sformatf("sweep_vec%0d", i), {24'd0, log0[i]},
                        {24'd0, sweep[i].a, sweep[i].b});
            @(negedge clk); hab0 = 0;
            @(posedge clk); #1;
            chk("fin_drop", {31'd0, fin0}, 0);
            chk("err_kept", {16'd0, err0}, {16'd0, runs[r].exp_err});
            @(negedge clk);
        end

        // Reset in ESPERA of vector 1 after vector 0 was scored wrong
        inject0 = 1; inj_a0 = 4'h0;
        hab0 = 1;
        @(posedge clk); #1;
        repeat (6) begin @(posedge clk); #1; end
        chk("mid_a", {28'd0, if0.a_valor}, 1);
        chk("mid_err", {16'd0, err0}, 1);
        rst0_n = 0; hab0 = 0; #1;
        chk("arst_a", {28'd0, if0.a_valor}, 0);
        chk("arst_iniciar", {31'd0, if0.iniciar}, 0);
        chk("arst_err", {16'd0, err0}, 0);
        chk("arst_fin", {31'd0, fin0}, 0);
        @(negedge clk); rst0_n = 1; inject0 = 0;
        repeat (4) @(negedge clk);
        log0.delete();
        hab0 = 1;
        @(posedge clk); #1;
        n = 0;
        while (!fin0 && n < 200) begin @(posedge clk); #1; n++; end
        chk("restart_cycles", n, 16);
        chk("restart_err", {16'd0, err0}, 0);
        if (log0.size() > 0) chk("restart_vec0", {24'd0, log0[0]}, 0);
        else chk("restart_vec0_present", 0, 1);
        @(negedge clk); hab0 = 0;

        // u1: listo never comes, 9 cycles per vector
        @(negedge clk); hab1 = 1;
        @(posedge clk); #1;
        n = 0;
        while (!fin1 && n < 200) begin
            @(posedge clk); #1; n++;
            if (n == 8) begin
                chk("tmo_early", {31'd0, tmo1}, 0);
                chk("err_early", {16'd0, err1}, 0);
            end
            if (n == 9) begin
                chk("tmo_first", {31'd0, tmo1}, 1);
                chk("err_first", {16'd0, err1}, 1);
            end
        end
        chk("tmo_cycles", n, 27);
        chk("tmo_err", {16'd0, err1}, 3);
        chk("tmo_flag", {31'd0, tmo1}, 1);
        chk("tmo_fin", {31'd0, fin1}, 1);
        chk("tmo_log_size", log1.size(), 3);
        @(negedge clk); hab1 = 0;

        // u2: LFSR vectors, minimum 2-cycle period
        @(negedge clk); hab2 = 1;
        @(posedge clk); #1;
        chk("lfsr_first_a", {28'd0, if2.a_valor}, 32'hA);
        chk("lfsr_first_b", {28'd0, if2.b_valor}, 32'h5);
        n = 0;
        while (!fin2 && n < 200) begin @(posedge clk); #1; n++; end
        chk("lfsr_cycles", n, 12);
        chk("lfsr_err", {16'd0, err2}, 0);
        chk("lfsr_tmo", {31'd0, tmo2}, 0);
        chk("lfsr_log_size", log2.size(), 6);
        for (int i = 0; i < 6; i++)
            if (log2.size() > i)
                chk($sformatf("lfsr_vec%0d", i), {24'd0, log2[i]},
                    {24'd0, lfsr[i].a, lfsr[i].b});
        @(negedge clk); hab2 = 0;

        // u3: every product wrong, 2-bit counter saturates
        @(negedge clk); hab3 = 1;
        @(posedge clk); #1;
        n = 0;
        while (!fin3 && n < 200) begin
            @(posedge clk); #1; n++;
            if (n == 4) chk("sat_two", {30'd0, err3}, 2);
        end
        chk("sat_cycles", n, 10);
        chk("sat_err", {30'd0, err3}, 3);
        chk("sat_tmo", {31'd0, tmo3}, 0);
        @(negedge clk); hab3 = 0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
